// File: rtl/byte_mem_ctrl_pkg.sv
// ============================================================================
// byte_mem_ctrl_pkg : shared encodings for the byte-serial memory controller
// Rev 1.0
// ============================================================================
`default_nettype none

package byte_mem_ctrl_pkg;

  localparam logic [1:0] LEN_BYTE         = 2'd0;
  localparam logic [1:0] LEN_HALF         = 2'd1;
  localparam logic [1:0] LEN_WORD         = 2'd2;
  localparam int         LEN_UNSIGNED_BIT = 2;
  localparam logic [1:0] IO_SEL           = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Anything that is not byte or half is treated as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] code);
    case (code)
      LEN_BYTE: byte_count = 3'd1;
      LEN_HALF: byte_count = 3'd2;
      default:  byte_count = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_mem_ctrl_res_extend.sv
// ============================================================================
// mem_res_extend : sign/zero extension of an assembled little-endian load
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_res_extend
  import byte_mem_ctrl_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [2:0]  i_len,
  output logic [31:0] o_res
);

  logic w_sign;

  always_comb begin
    w_sign = 1'b0;
    o_res  = i_raw;
    case (i_len[1:0])
      LEN_BYTE: begin
        w_sign = ~i_len[LEN_UNSIGNED_BIT] & i_raw[7];
        o_res  = {{24{w_sign}}, i_raw[7:0]};
      end
      LEN_HALF: begin
        w_sign = ~i_len[LEN_UNSIGNED_BIT] & i_raw[15];
        o_res  = {{16{w_sign}}, i_raw[15:0]};
      end
      default: o_res = i_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/byte_mem_ctrl.sv
// ============================================================================
// byte_mem_ctrl : byte-serial load/store sequencer over an 8-bit RAM/IO bus
// Optional IO stall counter: BYTE_MEM_CTRL_STALL_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module byte_mem_ctrl
  import byte_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int IO_SEL_LSB = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              valid,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        len,
  input  logic [31:0]       data,
  output logic              ready,
  output logic [31:0]       res,
  output logic [31:0]       io_stall_cnt
);

  state_t            r_state, w_state;
  logic [2:0]        r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [2:0]        r_len, w_len;
  logic [31:0]       r_data, w_data;
  logic [31:0]       r_raw, w_raw;
  logic              r_wflush, w_wflush;
  logic [ADDR_W-1:0] r_mem_a, w_mem_a;
  logic [7:0]        r_mem_dout, w_mem_dout;
  logic              r_mem_wr, w_mem_wr;
  logic              r_ready, w_ready;
  logic [31:0]       r_res, w_res;
  logic              w_stall;

  logic [2:0]        w_n;
  logic [ADDR_W-1:0] w_byte_addr;
  logic              w_byte_io, w_acc_io;
  logic [7:0]        w_data_byte;
  logic [31:0]       w_raw_cap, w_ext;

  assign w_n         = byte_count(r_len[1:0]);
  assign w_byte_addr = r_addr + ADDR_W'(r_cnt);
  assign w_byte_io   = (w_byte_addr[IO_SEL_LSB+1:IO_SEL_LSB] == IO_SEL);
  assign w_acc_io    = (addr[IO_SEL_LSB+1:IO_SEL_LSB] == IO_SEL);

  // In RD, r_cnt-1 is the index of the byte currently on mem_din.
  always_comb begin
    w_raw_cap   = r_raw;
    w_data_byte = r_data[31:24];
    case (r_cnt)
      3'd1:    w_raw_cap[7:0]   = mem_din;
      3'd2:    w_raw_cap[15:8]  = mem_din;
      3'd3:    w_raw_cap[23:16] = mem_din;
      3'd4:    w_raw_cap[31:24] = mem_din;
      default: w_raw_cap        = r_raw;
    endcase
    case (r_cnt)
      3'd0:    w_data_byte = r_data[7:0];
      3'd1:    w_data_byte = r_data[15:8];
      3'd2:    w_data_byte = r_data[23:16];
      default: w_data_byte = r_data[31:24];
    endcase
  end

  mem_res_extend u_extend (
    .i_raw (w_raw_cap),
    .i_len (r_len),
    .o_res (w_ext)
  );

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_addr     = r_addr;
    w_len      = r_len;
    w_data     = r_data;
    w_raw      = r_raw;
    w_wflush   = r_wflush;
    w_mem_a    = '0;
    w_mem_dout = r_mem_dout;
    w_mem_wr   = 1'b0;
    w_ready    = 1'b0;
    w_res      = r_res;
    w_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid && !flush_in) begin
          w_addr   = addr;
          w_len    = len;
          w_data   = data;
          w_raw    = '0;
          w_cnt    = 3'd0;
          w_wflush = 1'b0;
          if (wr) begin
            w_state = S_WR;
            // The first store byte goes out on the accept edge unless IO is full.
            if (w_acc_io && io_buffer_full) begin
              w_stall = 1'b1;
            end else begin
              w_mem_a    = addr;
              w_mem_dout = data[7:0];
              w_mem_wr   = 1'b1;
              w_cnt      = 3'd1;
            end
          end else begin
            w_state = S_RD;
            w_mem_a = addr;
          end
        end
      end
      S_RD: begin
        if (flush_in) begin
          w_state = S_IDLE;
        end else begin
          w_raw = w_raw_cap;
          if (r_cnt == w_n) begin
            w_state = S_DONE;
            w_ready = 1'b1;
            w_res   = w_ext;
          end else begin
            w_cnt = r_cnt + 3'd1;
            if (r_cnt + 3'd1 < w_n) begin
              w_mem_a = r_addr + ADDR_W'(r_cnt + 3'd1);
            end
          end
        end
      end
      S_WR: begin
        // A flush cannot abort a store; it only suppresses the completion pulse.
        w_wflush = r_wflush | flush_in;
        if (r_cnt == w_n) begin
          if (r_wflush || flush_in) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_DONE;
            w_ready = 1'b1;
          end
        end else if (w_byte_io && io_buffer_full) begin
          w_stall = 1'b1;
        end else begin
          w_mem_a    = w_byte_addr;
          w_mem_dout = w_data_byte;
          w_mem_wr   = 1'b1;
          w_cnt      = r_cnt + 3'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_raw      <= '0;
      r_wflush   <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_ready    <= 1'b0;
      r_res      <= '0;
    end else if (rdy_in) begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_addr     <= w_addr;
      r_len      <= w_len;
      r_data     <= w_data;
      r_raw      <= w_raw;
      r_wflush   <= w_wflush;
      r_mem_a    <= w_mem_a;
      r_mem_dout <= w_mem_dout;
      r_mem_wr   <= w_mem_wr;
      r_ready    <= w_ready;
      r_res      <= w_res;
    end
  end

`ifdef BYTE_MEM_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_stall_cnt <= '0;
    end else if (rdy_in && w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign io_stall_cnt = r_stall_cnt;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
  assign io_stall_cnt   = 32'd0;
`endif

  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;
  assign mem_wr   = r_mem_wr;
  assign ready    = r_ready;
  assign res      = r_res;

endmodule

`default_nettype wire

// File: tb/tb_byte_mem_ctrl.sv
// ============================================================================
// tb_byte_mem_ctrl : randomized self-checking bench for byte_mem_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_byte_mem_ctrl;

`ifdef BYTE_MEM_CTRL_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  len = '0;
  logic [31:0] data = '0;
  logic        ready;
  logic [31:0] res;
  logic [31:0] io_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int model_stalls = 0;
  bit full_pat[64];
  logic [7:0] ram [logic [31:0]];
  logic [39:0] wq[$];

  byte_mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .valid          (valid),
    .wr             (wr),
    .addr           (addr),
    .len            (len),
    .data           (data),
    .ready          (ready),
    .res            (res),
    .io_stall_cnt   (io_stall_cnt)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic bit is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // Memory device: one-cycle read latency, frozen together with the system.
  always @(posedge clk_in) begin
    if (rst_n_in && rdy_in) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) begin
        ram[mem_a] = mem_dout;
        wq.push_back({mem_a, mem_dout});
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_full(input int pct);
    for (int i = 0; i < 64; i++) full_pat[i] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic idle_quiet(input int cycles);
    bit busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in); #1;
      if (ready || mem_wr || mem_a != 32'd0) busy = 1'b1;
    end
    check("idle_quiet", 32'(busy), 32'd0);
  endtask

  // flush_at: 0 none, >0 cycle of flush, <0 random cycle inside the busy window.
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [2:0] l,
                         input logic [31:0] d, input int flush_at,
                         input int frz_from, input int frz_to);
    int n, e, issued, stalls, exp_rdy, got_rdy, cyc, lim, frz, nwr;
    logic [31:0] raw, exp_res;
    n   = (l[1:0] == 2'd0) ? 1 : (l[1:0] == 2'd1) ? 2 : 4;
    frz = (frz_from != 0) ? (frz_to - frz_from + 1) : 0;
    raw = '0;
    for (int i = 0; i < n; i++) raw |= 32'(ram_rd(a + 32'(i))) << (8 * i);
    exp_res = raw;
    if (!l[2] && l[1:0] == 2'd0 && raw[7])  exp_res = raw - 32'd256;
    if (!l[2] && l[1:0] == 2'd1 && raw[15]) exp_res = raw - 32'd65536;
    e = 0; issued = 0; stalls = 0;
    if (w) begin
      while (issued < n && e < 60) begin
        if (is_io(a + 32'(issued)) && full_pat[e]) stalls++;
        else issued++;
        e++;
      end
    end
    exp_rdy = w ? e + 1 : n + 2 + frz;
    if (flush_at < 0) flush_at = w ? $urandom_range(1, e) : $urandom_range(1, n + 1);
    lim = exp_rdy + 4;
    wq.delete();
    got_rdy = 0;
    cyc = 0;
    @(negedge clk_in);
    valid = 1'b1; wr = w; addr = a; len = l; data = d;
    while (cyc < lim) begin
      io_buffer_full = full_pat[cyc % 64];
      flush_in = (flush_at > 0 && cyc == flush_at);
      if (flush_in) valid = 1'b0;
      rdy_in = !(frz > 0 && cyc >= frz_from && cyc <= frz_to);
      @(posedge clk_in); #1;
      cyc++;
      if (frz > 0 && cyc > frz_from && cyc <= frz_to + 1)
        check("frz_mem_a", mem_a, a + 32'(frz_from - 1));
      if (!w && frz == 0 && flush_at == 0) begin
        if (cyc <= n) check("rd_mem_a", mem_a, a + 32'(cyc - 1));
        else if (cyc == n + 1) check("rd_mem_a_end", mem_a, 32'd0);
      end
      if (ready) begin
        got_rdy = cyc;
        break;
      end
      @(negedge clk_in);
    end
    @(negedge clk_in);
    flush_in = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
    @(posedge clk_in); #1;
    valid = 1'b0;
    if (got_rdy != 0) check("ready_pulse", 32'(ready), 32'd0);
    check("ready_cycle", got_rdy, (flush_at == 0) ? exp_rdy : 0);
    if (!w && flush_at == 0) check("res", res, exp_res);
    idle_quiet(3);
    nwr = wq.size();
    check("wr_count", nwr, w ? n : 0);
    for (int i = 0; i < nwr && i < n && w; i++) begin
      check("wr_addr", wq[i][39:8], a + 32'(i));
      check("wr_byte", 32'(wq[i][7:0]), 32'(d[8*i +: 8]));
    end
    if (w) model_stalls += stalls;
    check("stall_cnt", io_stall_cnt, STALL_EN ? 32'(model_stalls) : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  l;
    bit          w;
    int          cat;

    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_stall", io_stall_cnt, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    set_full(0);
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    run_txn(1'b0, 32'h100, 3'b010, 32'h0, 0, 0, 0);
    ram[32'h10] = 8'h80;
    run_txn(1'b0, 32'h10, 3'b000, 32'h0, 0, 0, 0);
    run_txn(1'b0, 32'h10, 3'b100, 32'h0, 0, 0, 0);
    ram[32'h20] = 8'h01; ram[32'h21] = 8'h80;
    run_txn(1'b0, 32'h20, 3'b001, 32'h0, 0, 0, 0);

    for (int i = 0; i < 64; i++) full_pat[i] = (i >= 2 && i <= 4);
    run_txn(1'b1, 32'h0003_0000, 3'b010, 32'hA1B2_C3D4, 0, 0, 0);
    set_full(0);
    run_txn(1'b0, 32'h100, 3'b010, 32'h0, 3, 0, 0);
    run_txn(1'b0, 32'h100, 3'b010, 32'h0, 0, 0, 0);
    run_txn(1'b1, 32'h0000_0200, 3'b001, 32'h0000_BEEF, 1, 0, 0);
    run_txn(1'b0, 32'h100, 3'b010, 32'h0, 0, 2, 5);
    run_txn(1'b0, 32'hFFFF_FFFF, 3'b010, 32'h0, 0, 0, 0);

    @(negedge clk_in);
    valid = 1'b1; wr = 1'b0; addr = 32'h200; len = 3'b010; flush_in = 1'b1;
    @(posedge clk_in); #1;
    check("flush_acc_mem_a", mem_a, 32'd0);
    valid = 1'b0; flush_in = 1'b0;
    idle_quiet(6);

    for (int t = 0; t < 60; t++) begin
      w   = 1'($urandom_range(0, 1));
      l   = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      cat = $urandom_range(0, 2);
      if (cat == 0)      a = 32'($urandom_range(0, 16'hFFFF));
      else if (cat == 1) a = 32'h0003_0000 | 32'($urandom_range(0, 16'hFFFF));
      else               a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      set_full(35);
      run_txn(w, a, l, $urandom, ($urandom_range(0, 5) == 0) ? -1 : 0, 0, 0);
    end

    @(negedge clk_in);
    io_buffer_full = 1'b0;
    valid = 1'b1; wr = 1'b1; addr = 32'h40; len = 3'b010; data = 32'h1234_5678;
    @(posedge clk_in); #1;
    valid = 1'b0;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(posedge clk_in); #1;
    check("mid_rst_mem_a", mem_a, 32'd0);
    check("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    check("mid_rst_mem_dout", 32'(mem_dout), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_res", res, 32'd0);
    check("mid_rst_stall", io_stall_cnt, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle_quiet(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
